uart_access_arbiter: RTL and testbench

Arbitrates exclusive ownership of the shared UART peripheral among N requesters (harts/masters), each identified by an 8-bit access ID. It sits in the system clock domain next to the UART register interface and replaces the simple access-ID FIFO. Ownership is granted in round-robin order and held until release or timeout. The current owner ID is exported so the register interface can reject data-register accesses from non-owners.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_access_arbiter_rr_pick.sv | 28 ++
 rtl/uart_access_arbiter.sv | 127 ++++++++++++
 tb/tb_uart_access_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART access arbiter.
// Imported by the arbiter top and its round-robin selector.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int NUM_REQ_DEF  = 4;
  localparam int ID_WIDTH_DEF = 8;

endpackage

// File: rtl/uart_access_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after
// the pointer, wrapping, returned one-hot with a valid flag.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  oh_o,
  output logic          valid_o
);

  logic [PW-1:0] j;

  always_comb begin
    oh_o    = '0;
    valid_o = 1'b0;
    j       = '0;
    for (int i = 0; i < N; i++) begin
      j = PW'((int'(ptr_i) + i) % N);
      if (!valid_o && req_i[j]) begin
        oh_o[j] = 1'b1;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_access_arbiter.sv
// Round-robin exclusive-ownership arbiter for the shared UART, with
// hold timeout and a drain phase that lets in-flight TX bytes finish.
module uart_access_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = NUM_REQ_DEF,
  parameter int ID_WIDTH      = ID_WIDTH_DEF,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                        clk_i,
  input  logic                        arst_ni,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*ID_WIDTH-1:0] req_id_i,
  input  logic [NUM_REQ-1:0]          release_i,
  input  logic [TIMEOUT_WIDTH-1:0]    timeout_i,
  input  logic                        tx_idle_i,
  output logic [NUM_REQ-1:0]          gnt_o,
  output logic                        owner_valid_o,
  output logic [ID_WIDTH-1:0]         owner_id_o,
  output logic                        timeout_irq_o
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_t               state_q, state_d;
  logic [NUM_REQ-1:0]       gnt_q, gnt_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]      id_q, id_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic                     irq_q, irq_d;

  logic [NUM_REQ-1:0]  pick_oh;
  logic                pick_vld;
  logic [IW-1:0]       pick_idx;
  logic [ID_WIDTH-1:0] ids [NUM_REQ];
  logic                tmo_hit;
  logic                own_done;

  rr_pick #(
    .N  (NUM_REQ),
    .PW (IW)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .oh_o    (pick_oh),
    .valid_o (pick_vld)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ids[i] = req_id_i[i*ID_WIDTH +: ID_WIDTH];
      if (pick_oh[i]) pick_idx = IW'(i);
    end
  end

  assign tmo_hit  = (timeout_i != '0) &&
                    (cnt_q == timeout_i - 1'b1);
  assign own_done = release_i[idx_q] || !req_i[idx_q];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    irq_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          gnt_d   = pick_oh;
          idx_d   = pick_idx;
          id_d    = ids[pick_idx];
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        // release beats a coincident timeout, so no irq then
        if (own_done) begin
          state_d = DRAIN;
        end else if (tmo_hit) begin
          state_d = DRAIN;
          irq_d   = 1'b1;
        end
      end
      DRAIN: begin
        if (tx_idle_i) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = (int'(idx_q) == NUM_REQ - 1) ?
                    '0 : idx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      irq_q   <= irq_d;
    end
  end

  assign gnt_o         = gnt_q;
  assign owner_valid_o = (state_q != IDLE);
  assign owner_id_o    = id_q;
  assign timeout_irq_o = irq_q;

endmodule

// File: tb/tb_uart_access_arbiter.sv
// Bench for uart_access_arbiter: vector table, corner sequences,
// and random traffic against an ownership-level reference model.
module tb_uart_access_arbiter;

  localparam int N   = 4;
  localparam int IDW = 8;
  localparam int TW  = 16;

  logic           clk = 1'b0;
  logic           arst_ni;
  logic [N-1:0]   req, rel;
  logic [N*IDW-1:0] ids;
  logic [TW-1:0]  tmo;
  logic           idle;
  logic [N-1:0]   gnt;
  logic           valid;
  logic [IDW-1:0] id;
  logic           irq;

  int ntests = 0;
  int nfail  = 0;

  uart_access_arbiter #(
    .NUM_REQ       (N),
    .ID_WIDTH      (IDW),
    .TIMEOUT_WIDTH (TW)
  ) dut (
    .clk_i         (clk),
    .arst_ni       (arst_ni),
    .req_i         (req),
    .req_id_i      (ids),
    .release_i     (rel),
    .timeout_i     (tmo),
    .tx_idle_i     (idle),
    .gnt_o         (gnt),
    .owner_valid_o (valid),
    .owner_id_o    (id),
    .timeout_irq_o (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] rel;
    logic       idle;
    logic [3:0] gnt;
    logic       v;
    logic [7:0] id;
    logic       irq;
  } vec_t;

  vec_t tv [12];

  int          m_owner, m_ptr, m_held;
  bit          m_drain, m_irq;
  logic [7:0]  m_id;

  function automatic logic [31:0] pk(input logic [3:0] g,
      input logic v, input logic i, input logic [7:0] d);
    return {18'd0, g, v, i, d};
  endfunction

  function automatic logic [31:0] outs();
    return pk(gnt, valid, irq, id);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
      input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst_ni = 1'b0;
    req  = '0;
    rel  = '0;
    idle = 1'b1;
    tmo  = '0;
    #12;
    @(negedge clk);
    arst_ni = 1'b1;
  endtask

  // Ownership-level model: who owns, whether draining, cycles held.
  task automatic model_step();
    m_irq = 1'b0;
    if (m_owner < 0) begin
      for (int i = 0; i < N; i++) begin
        int j;
        j = (m_ptr + i) % N;
        if (m_owner < 0 && req[j]) begin
          m_owner = j;
          m_held  = 0;
          m_drain = 1'b0;
          m_id    = ids[j*IDW +: IDW];
        end
      end
    end else if (!m_drain) begin
      int old;
      old = m_held;
      if (m_held < 65535) m_held++;
      if (rel[m_owner] || !req[m_owner]) begin
        m_drain = 1'b1;
      end else if (tmo != 0 && old == int'(tmo) - 1) begin
        m_drain = 1'b1;
        m_irq   = 1'b1;
      end
    end else if (idle) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end
  endtask

  function automatic logic [31:0] model_out();
    logic [3:0] g;
    g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
    return pk(g, m_owner >= 0, m_irq, m_id);
  endfunction

  initial begin
    int exp_order [5];
    int w;

    arst_ni = 1'b0;
    ids = 32'h44332211;
    tv[0]  = '{4'b0110, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'h22, 1'b0};
    tv[1]  = '{4'b0110, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h22, 1'b0};
    tv[2]  = '{4'b0110, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h22, 1'b0};
    tv[3]  = '{4'b0110, 4'b0000, 1'b1, 4'b0100, 1'b1, 8'h33, 1'b0};
    tv[4]  = '{4'b0010, 4'b0000, 1'b0, 4'b0100, 1'b1, 8'h33, 1'b0};
    tv[5]  = '{4'b0010, 4'b0000, 1'b0, 4'b0100, 1'b1, 8'h33, 1'b0};
    tv[6]  = '{4'b0010, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h33, 1'b0};
    tv[7]  = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'h22, 1'b0};
    tv[8]  = '{4'b0010, 4'b0001, 1'b1, 4'b0010, 1'b1, 8'h22, 1'b0};
    tv[9]  = '{4'b0000, 4'b0000, 1'b1, 4'b0010, 1'b1, 8'h22, 1'b0};
    tv[10] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h22, 1'b0};
    tv[11] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h22, 1'b0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("reset_idle", outs(), 32'd0);
    end

    for (int i = 0; i < 12; i++) begin
      req  = tv[i].req;
      rel  = tv[i].rel;
      idle = tv[i].idle;
      tick();
      chk($sformatf("vec%0d", i), outs(),
          pk(tv[i].gnt, tv[i].v, tv[i].irq, tv[i].id));
    end
    rel = '0;

    // timeout after 5 held cycles, then grant moves on
    do_reset();
    tmo = 16'd5;
    req = 4'b0011;
    tick();
    chk("tmo_grant", outs(), pk(4'b0001, 1'b1, 1'b0, 8'h11));
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("tmo_pre", outs(), pk(4'b0001, 1'b1, 1'b0, 8'h11));
    end
    tick();
    chk("tmo_irq", outs(), pk(4'b0001, 1'b1, 1'b1, 8'h11));
    tick();
    chk("tmo_idle", outs(), pk(4'b0000, 1'b0, 1'b0, 8'h11));
    tick();
    chk("tmo_next", outs(), pk(4'b0010, 1'b1, 1'b0, 8'h22));

    // drain holds ownership while TX is busy
    do_reset();
    req  = 4'b0001;
    idle = 1'b0;
    tick();
    rel = 4'b0001;
    tick();
    rel = '0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("drain_hold", outs(), pk(4'b0001, 1'b1, 1'b0, 8'h11));
    end
    idle = 1'b1;
    tick();
    chk("drain_clr", outs(), pk(4'b0000, 1'b0, 1'b0, 8'h11));

    // release coincident with timeout: drain, no irq
    do_reset();
    tmo  = 16'd3;
    req  = 4'b0001;
    idle = 1'b0;
    tick();
    tick();
    tick();
    rel = 4'b0001;
    tick();
    rel = '0;
    chk("sim_rel", outs(), pk(4'b0001, 1'b1, 1'b0, 8'h11));
    tick();
    chk("sim_drain", outs(), pk(4'b0001, 1'b1, 1'b0, 8'h11));
    idle = 1'b1;
    tick();
    chk("sim_exit", outs(), pk(4'b0000, 1'b0, 1'b0, 8'h11));

    // fairness with all requesting
    do_reset();
    req = 4'hF;
    exp_order = '{0, 1, 2, 3, 0};
    for (int r = 0; r < 5; r++) begin
      w = 0;
      do begin
        tick();
        chk("onehot", 32'($onehot0(gnt)), 32'd1);
        w++;
      end while (gnt == 0 && w < 8);
      chk("fair_owner", 32'(gnt), 32'(1 << exp_order[r]));
      if (r < 4) begin
        rel = gnt;
        tick();
        rel = '0;
      end
    end

    // async reset during GRANT
    #2;
    arst_ni = 1'b0;
    #1;
    chk("async_rst", outs(), 32'd0);

    // random traffic vs model
    do_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_held  = 0;
    m_drain = 1'b0;
    m_irq   = 1'b0;
    m_id    = '0;
    ids     = $urandom;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 9) == 0) ids = $urandom;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
        rel[b] = ($urandom_range(0, 5) == 0);
      end
      idle = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 3))
          0: tmo = 16'd0;
          1: tmo = 16'd2;
          2: tmo = 16'd5;
          default: tmo = 16'd9;
        endcase
      end
      model_step();
      tick();
      chk("rand", outs(), model_out());
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
